// File: rtl/mem_port_if.sv
// Bundle of fetch, data and memory-side signals around the unified memory arbiter.
// The arbiter uses the slave view; the pipeline/memory model uses the master view.
interface mem_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          acc_err;
  logic          stall_if;
  logic          stall_mem;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr,
           mem_wdata, acc_err, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr,
           mem_wdata, acc_err, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage access to one single-ported memory, with burst fairness and timeout.
// Optional wait-cycle statistics outputs are enabled by defining MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_DBURST = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_port_if.slave    bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]  stat_if_wait,
  output logic [31:0]  stat_dm_wait
`endif
);

  localparam int BW = (MAX_DBURST > 0) ? $clog2(MAX_DBURST + 1) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   burst_cnt_r;
  logic [TW-1:0]   tmo_cnt_r;
  logic            burst_hit_s;
  logic            if_wins_s;
  logic            grant_if_s;
  logic            grant_dm_s;
  logic            tmo_hit_s;

  // Priority is decided on the raw requests; a requester seeing its ready this cycle is only masked from the grant.
  always_comb begin
    burst_hit_s = (burst_cnt_r == BW'(MAX_DBURST));
    if_wins_s   = bus.if_req & (~bus.dm_req | burst_hit_s);
    tmo_hit_s   = (TIMEOUT != 0) && (tmo_cnt_r == TW'(TIMEOUT - 1));
    grant_if_s  = 1'b0;
    grant_dm_s  = 1'b0;
    if (state_r == IDLE) begin
      grant_if_s = if_wins_s & ~bus.if_ready;
      grant_dm_s = bus.dm_req & ~if_wins_s & ~bus.dm_ready;
    end else begin
      grant_if_s = 1'b0;
      grant_dm_s = 1'b0;
    end
  end

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;

  // Arbitration FSM with registered memory request, ready pulses, read data and timeout abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      burst_cnt_r   <= '0;
      tmo_cnt_r     <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.dm_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.dm_ready  <= 1'b0;
      bus.acc_err   <= 1'b0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.dm_ready <= 1'b0;
      bus.acc_err  <= 1'b0;

      if (!bus.if_req || grant_if_s) begin
        burst_cnt_r <= '0;
      end else if (grant_dm_s && !burst_hit_s) begin
        burst_cnt_r <= burst_cnt_r + BW'(1'b1);
      end else begin
        burst_cnt_r <= burst_cnt_r;
      end

      case (state_r)
        IDLE: begin
          tmo_cnt_r <= '0;
          if (grant_if_s) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.if_addr;
            state_r      <= BUSY_I;
          end else if (grant_dm_s) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            state_r       <= BUSY_D;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            tmo_cnt_r   <= '0;
            state_r     <= IDLE;
            if (state_r == BUSY_I) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_ready <= 1'b1;
            end else begin
              // Stores leave the last load data untouched.
              if (!bus.mem_we) begin
                bus.dm_rdata <= bus.mem_rdata;
              end else begin
                bus.dm_rdata <= bus.dm_rdata;
              end
              bus.dm_ready <= 1'b1;
            end
          end else if (tmo_hit_s) begin
            bus.mem_req <= 1'b0;
            bus.acc_err <= 1'b1;
            tmo_cnt_r   <= '0;
            state_r     <= IDLE;
            if (state_r == BUSY_I) begin
              bus.if_rdata <= '0;
              bus.if_ready <= 1'b1;
            end else begin
              bus.dm_rdata <= '0;
              bus.dm_ready <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
          end
        end
        default: begin
          bus.mem_req <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating counts of cycles each stage spends stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_wait <= 32'd0;
      stat_dm_wait <= 32'd0;
    end else begin
      if (bus.stall_if && (stat_if_wait != 32'hFFFF_FFFF)) begin
        stat_if_wait <= stat_if_wait + 32'd1;
      end else begin
        stat_if_wait <= stat_if_wait;
      end
      if (bus.stall_mem && (stat_dm_wait != 32'hFFFF_FFFF)) begin
        stat_dm_wait <= stat_dm_wait + 32'd1;
      end else begin
        stat_dm_wait <= stat_dm_wait;
      end
    end
  end
`endif

endmodule
